control_decode_stage: RTL and testbench
=======================================

// Module: control_decode_stage
// PURPOSE
//  Registered, parametrised successor of the combinational decoder: decodes opcode/funct and loads the
//  control bundle into the ID/EX register. It honours stall/flush from the hazard unit, flags illegal
//  opcodes and runs a halt-drain FSM that freezes fetch and signals halted_o once the pipeline is empty.
// PARAMETERS
//  NB_OP 6 opcode width | NB_FUNCT 6 funct width | N_REGDEST 2 regDest select width
//  OP_J 6'b110001 opcode of J | DRAIN_CYCLES 4 post-decode stages to empty before halt (1..15)
// PORTS
//  clock_i in 1 clock | reset_i in 1 async active-high reset
//  valid_i in 1 instruction valid | opcode_i in NB_OP | funct_i in NB_FUNCT
//  stall_i in 1 hold ID/EX | flush_i in 1 squash decode slot / abort drain
//  valid_o out 1 | tipeI_o, shamt_o, beq_o, bne_o, jump_o out 1 each | pc_src_o out 2
//  regDest_signal_o out N_REGDEST | mem_signals_o out 6 | wb_signals_o out 3 | opcode_o out NB_OP
//  halt_signal_o out 1 | illegal_o out 1 | fetch_enable_o out 1 | halted_o out 1
// BEHAVIOUR
//  Reset (async, active-high): every bundle output, valid_o, illegal_o and halted_o = 0. fetch_enable_o = 1.
//   state=RUN, drain counter=0. Reset mid-drain or while HALTED returns to RUN.
//  Encodings: mem[5]=sign [4]=read [3]=write [2:0]=W/H/B one-hot (100/010/001).
//   wb[2]=regWrite [1:0] 00 mem, 01 alu, 10 pc. pc_src 00 reg, 01 jump, 10 branch.
//   regDest 00 rt, 01 rd, 10 r31.
//  Decode table (all unlisted fields 0):
//   op 0, funct 0: NOP. op 111110: NOP.
//   op 0, funct 001000 JR: jump=1.
//   op 0, funct 001001 JALR: jump=1, regDest 01, wb 110.
//   op 0, other funct: regDest 01, wb 101. shamt=1 if funct is 000010 or 000011.
//   001000/001010/001100/001101/001110/001111 (imm ALU): tipeI, wb 101.
//   Loads, all with tipeI and wb 100. mem value per opcode:
//    LB 100000: 110001 | LH 100001: 110010 | LW 100011: 110100
//    LBU 100100: 010001 | LHU 100101: 010010 | LWU 010011: 010100
//   Stores, all with tipeI and wb 000. mem value per opcode:
//    SB 101000: 001001 | SH 101001: 001010 | SW 101011: 001100
//   BEQ 000100: tipeI, beq, pc_src 10. BNE 000101: tipeI, bne, pc_src 10.
//   OP_J: jump, pc_src 01. JAL 000011: jump, pc_src 01, regDest 10, wb 110.
//   HALT 111111: halt_signal=1.
//   Any other opcode: illegal=1, all controls 0, no write-back and no memory access.
//  ID/EX register update, 1-cycle latency, in this priority order:
//   1. flush_i=1: load bubble (valid_o=0, all bundle outputs 0). flush_i wins over stall_i.
//   2. stall_i=1: hold every output unchanged.
//   3. valid_i=0 or state!=RUN: load bubble.
//   4. Otherwise: load the decoded bundle, valid_o=1, opcode_o=opcode_i.
//  "Accept" = case 4 with a HALT opcode.
//  Halt FSM:
//   RUN: on accept, state becomes DRAIN, counter=DRAIN_CYCLES and fetch_enable_o=0 from the same edge.
//   DRAIN: counter decrements each edge; when counter==1 the next edge enters HALTED.
//    flush_i=1 in DRAIN aborts: state=RUN, counter=0, fetch_enable_o=1.
//   HALTED: halted_o=1, fetch_enable_o=0, bubbles only. Sticky until reset.
//   halted_o rises exactly DRAIN_CYCLES edges after the accept edge.
//  No decoded output may be X for any opcode/funct input.
// TESTING
//  T1 reset asserted mid-cycle -> all outputs 0 immediately, fetch_enable_o=1, halted_o=0.
//  T2 valid ADDI (op 001000) -> next edge: valid_o=1, tipeI_o=1, wb_signals_o=101, mem_signals_o=0.
//  T3 LW loaded, then stall_i=1 for 2 cycles with BEQ on input -> mem 110100 / wb 100 held;
//     stall released -> beq_o=1, pc_src_o=10.
//  T4 BEQ with flush_i=1 and stall_i=1 together -> bubble: valid_o=0, beq_o=0.
//  T5 HALT accepted, DRAIN_CYCLES=4 -> fetch_enable_o=0 after the accept edge, halted_o=1 four edges later;
//     repeat with flush_i on the 2nd drain cycle -> back to RUN, fetch_enable_o=1, halted_o stays 0.
//  T6 opcode 011111 valid -> illegal_o=1, wb_signals_o=000, mem_signals_o=000000;
//     JALR -> wb_signals_o=110, regDest_signal_o=01.

Source files
------------

// File: rtl/control_decode_stage.sv
// Registered decode stage: decodes opcode/funct into the ID/EX control bundle,
// honours stall/flush and drains the pipeline before halting.
//   state  | meaning
//   RUN    | normal decode, fetch enabled
//   DRAIN  | HALT accepted, waiting for post-decode stages to empty
//   HALTED | pipeline empty, bubbles only until reset
module control_decode_stage #(
  parameter int NB_OP = 6,
  parameter int NB_FUNCT = 6,
  parameter int N_REGDEST = 2,
  parameter logic [NB_OP-1:0] OP_J = NB_OP'(6'b110001),
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [NB_OP-1:0]     opcode_i,
  input  logic [NB_FUNCT-1:0]  funct_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  output logic                 tipeI_o,
  output logic                 shamt_o,
  output logic                 beq_o,
  output logic                 bne_o,
  output logic                 jump_o,
  output logic [1:0]           pc_src_o,
  output logic [N_REGDEST-1:0] regDest_signal_o,
  output logic [5:0]           mem_signals_o,
  output logic [2:0]           wb_signals_o,
  output logic [NB_OP-1:0]     opcode_o,
  output logic                 halt_signal_o,
  output logic                 illegal_o,
  output logic                 fetch_enable_o,
  output logic                 halted_o
);

  localparam logic [NB_OP-1:0] OP_RTYPE = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OP_ADDI  = NB_OP'(6'b001000);
  localparam logic [NB_OP-1:0] OP_SLTI  = NB_OP'(6'b001010);
  localparam logic [NB_OP-1:0] OP_ANDI  = NB_OP'(6'b001100);
  localparam logic [NB_OP-1:0] OP_ORI   = NB_OP'(6'b001101);
  localparam logic [NB_OP-1:0] OP_XORI  = NB_OP'(6'b001110);
  localparam logic [NB_OP-1:0] OP_LUI   = NB_OP'(6'b001111);
  localparam logic [NB_OP-1:0] OP_LB    = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_LH    = NB_OP'(6'b100001);
  localparam logic [NB_OP-1:0] OP_LW    = NB_OP'(6'b100011);
  localparam logic [NB_OP-1:0] OP_LBU   = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_LHU   = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_LWU   = NB_OP'(6'b010011);
  localparam logic [NB_OP-1:0] OP_SB    = NB_OP'(6'b101000);
  localparam logic [NB_OP-1:0] OP_SH    = NB_OP'(6'b101001);
  localparam logic [NB_OP-1:0] OP_SW    = NB_OP'(6'b101011);
  localparam logic [NB_OP-1:0] OP_BEQ   = NB_OP'(6'b000100);
  localparam logic [NB_OP-1:0] OP_BNE   = NB_OP'(6'b000101);
  localparam logic [NB_OP-1:0] OP_JAL   = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_NOP   = NB_OP'(6'b111110);
  localparam logic [NB_OP-1:0] OP_HALT  = NB_OP'(6'b111111);

  localparam logic [NB_FUNCT-1:0] F_NOP  = NB_FUNCT'(6'b000000);
  localparam logic [NB_FUNCT-1:0] F_JR   = NB_FUNCT'(6'b001000);
  localparam logic [NB_FUNCT-1:0] F_JALR = NB_FUNCT'(6'b001001);
  localparam logic [NB_FUNCT-1:0] F_SRL  = NB_FUNCT'(6'b000010);
  localparam logic [NB_FUNCT-1:0] F_SRA  = NB_FUNCT'(6'b000011);

  localparam logic [N_REGDEST-1:0] RD_RD  = N_REGDEST'(1);
  localparam logic [N_REGDEST-1:0] RD_R31 = N_REGDEST'(2);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic                 valid;
    logic                 tipei;
    logic                 shamt;
    logic                 beq;
    logic                 bne;
    logic                 jump;
    logic [1:0]           pc_src;
    logic [N_REGDEST-1:0] regdest;
    logic [5:0]           mem;
    logic [2:0]           wb;
    logic [NB_OP-1:0]     opcode;
    logic                 halt;
    logic                 illegal;
  } bundle_t;

  state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  bundle_t dec, bundle_q;
  logic    accept;

  always_comb begin
    dec = '0;
    dec.valid = 1'b1;
    dec.opcode = opcode_i;
    case (opcode_i)
      OP_RTYPE: begin
        if (funct_i == F_JR) begin
          dec.jump = 1'b1;
        end else if (funct_i == F_JALR) begin
          dec.jump = 1'b1;
          dec.regdest = RD_RD;
          dec.wb = 3'b110;
        end else if (funct_i != F_NOP) begin
          dec.regdest = RD_RD;
          dec.wb = 3'b101;
          dec.shamt = (funct_i == F_SRL) || (funct_i == F_SRA);
        end
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.tipei = 1'b1;
        dec.wb = 3'b101;
      end
      OP_LB:  begin dec.tipei = 1'b1; dec.wb = 3'b100; dec.mem = 6'b110001; end
      OP_LH:  begin dec.tipei = 1'b1; dec.wb = 3'b100; dec.mem = 6'b110010; end
      OP_LW:  begin dec.tipei = 1'b1; dec.wb = 3'b100; dec.mem = 6'b110100; end
      OP_LBU: begin dec.tipei = 1'b1; dec.wb = 3'b100; dec.mem = 6'b010001; end
      OP_LHU: begin dec.tipei = 1'b1; dec.wb = 3'b100; dec.mem = 6'b010010; end
      OP_LWU: begin dec.tipei = 1'b1; dec.wb = 3'b100; dec.mem = 6'b010100; end
      OP_SB:  begin dec.tipei = 1'b1; dec.mem = 6'b001001; end
      OP_SH:  begin dec.tipei = 1'b1; dec.mem = 6'b001010; end
      OP_SW:  begin dec.tipei = 1'b1; dec.mem = 6'b001100; end
      OP_BEQ: begin dec.tipei = 1'b1; dec.beq = 1'b1; dec.pc_src = 2'b10; end
      OP_BNE: begin dec.tipei = 1'b1; dec.bne = 1'b1; dec.pc_src = 2'b10; end
      OP_J:   begin dec.jump = 1'b1; dec.pc_src = 2'b01; end
      OP_JAL: begin
        dec.jump = 1'b1;
        dec.pc_src = 2'b01;
        dec.regdest = RD_R31;
        dec.wb = 3'b110;
      end
      OP_NOP:  ;
      OP_HALT: dec.halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  assign accept = valid_i && !flush_i && !stall_i && (state_q == RUN) && (opcode_i == OP_HALT);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          state_d = DRAIN;
          cnt_d = 4'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (flush_i) begin
          state_d = RUN;
          cnt_d = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = HALTED;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HALTED: ;
      default: begin
        state_d = RUN;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // Stall holds the register; flush and non-RUN states load a bubble.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      bundle_q <= '0;
    end else if (flush_i) begin
      bundle_q <= '0;
    end else if (!stall_i) begin
      if (valid_i && state_q == RUN) bundle_q <= dec;
      else bundle_q <= '0;
    end
  end

  assign valid_o          = bundle_q.valid;
  assign tipeI_o          = bundle_q.tipei;
  assign shamt_o          = bundle_q.shamt;
  assign beq_o            = bundle_q.beq;
  assign bne_o            = bundle_q.bne;
  assign jump_o           = bundle_q.jump;
  assign pc_src_o         = bundle_q.pc_src;
  assign regDest_signal_o = bundle_q.regdest;
  assign mem_signals_o    = bundle_q.mem;
  assign wb_signals_o     = bundle_q.wb;
  assign opcode_o         = bundle_q.opcode;
  assign halt_signal_o    = bundle_q.halt;
  assign illegal_o        = bundle_q.illegal;
  assign fetch_enable_o   = (state_q == RUN);
  assign halted_o         = (state_q == HALTED);

endmodule

// File: tb/tb_control_decode_stage.sv
// Self-checking bench for control_decode_stage: decode table vectors, directed
// stall/flush/halt sequences and random stimulus against a behavioural model.
module tb_control_decode_stage;
  localparam int DC = 4;

  logic clock_i = 1'b0;
  logic reset_i, valid_i, stall_i, flush_i;
  logic [5:0] opcode_i, funct_i;
  logic valid_o, tipeI_o, shamt_o, beq_o, bne_o, jump_o;
  logic [1:0] pc_src_o, regDest_signal_o;
  logic [5:0] mem_signals_o, opcode_o;
  logic [2:0] wb_signals_o;
  logic halt_signal_o, illegal_o, fetch_enable_o, halted_o;

  control_decode_stage #(.DRAIN_CYCLES(DC)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .opcode_i(opcode_i),
    .funct_i(funct_i), .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o),
    .tipeI_o(tipeI_o), .shamt_o(shamt_o), .beq_o(beq_o), .bne_o(bne_o), .jump_o(jump_o),
    .pc_src_o(pc_src_o), .regDest_signal_o(regDest_signal_o), .mem_signals_o(mem_signals_o),
    .wb_signals_o(wb_signals_o), .opcode_o(opcode_o), .halt_signal_o(halt_signal_o),
    .illegal_o(illegal_o), .fetch_enable_o(fetch_enable_o), .halted_o(halted_o)
  );

  always #5 clock_i = ~clock_i;

  int total = 0;
  int bad = 0;

  logic [26:0] m_bundle;
  int m_drain;
  bit m_halted;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [26:0] exp;
    string       name;
  } vec_t;

  // {valid, tipeI, shamt, beq, bne, jump, pc_src, regDest, mem, wb, opcode, halt, illegal}
  function automatic logic [26:0] mk(logic v, logic ti, logic sh, logic bq, logic bn, logic j,
                                     logic [1:0] pc, logic [1:0] rd, logic [5:0] mem,
                                     logic [2:0] wb, logic [5:0] op, logic h, logic il);
    return {v, ti, sh, bq, bn, j, pc, rd, mem, wb, op, h, il};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {valid_o, tipeI_o, shamt_o, beq_o, bne_o, jump_o, pc_src_o, regDest_signal_o,
            mem_signals_o, wb_signals_o, opcode_o, halt_signal_o, illegal_o};
  endfunction

  function automatic logic [26:0] ref_decode(logic [5:0] op, logic [5:0] f);
    logic ti = 0, sh = 0, bq = 0, bn = 0, j = 0, h = 0, il = 0;
    logic [1:0] pc = 0, rd = 0;
    logic [5:0] mem = 0;
    logic [2:0] wb = 0;
    if (op == 6'b000000) begin
      if (f == 6'b001000) j = 1;
      else if (f == 6'b001001) begin j = 1; rd = 2'b01; wb = 3'b110; end
      else if (f != 0) begin rd = 2'b01; wb = 3'b101; sh = (f == 6'd2 || f == 6'd3); end
    end else if (op inside {6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111}) begin
      ti = 1; wb = 3'b101;
    end else if (op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b010011}) begin
      ti = 1; wb = 3'b100;
      mem[5] = (op[5:2] == 4'b1000);
      mem[4] = 1;
      case (op)
        6'b100000, 6'b100100: mem[0] = 1;
        6'b100001, 6'b100101: mem[1] = 1;
        default:              mem[2] = 1;
      endcase
    end else if (op inside {6'b101000, 6'b101001, 6'b101011}) begin
      ti = 1; mem[3] = 1;
      mem[2:0] = (op == 6'b101000) ? 3'b001 : (op == 6'b101001) ? 3'b010 : 3'b100;
    end else if (op == 6'b000100) begin ti = 1; bq = 1; pc = 2'b10; end
    else if (op == 6'b000101) begin ti = 1; bn = 1; pc = 2'b10; end
    else if (op == 6'b110001) begin j = 1; pc = 2'b01; end
    else if (op == 6'b000011) begin j = 1; pc = 2'b01; rd = 2'b10; wb = 3'b110; end
    else if (op == 6'b111111) h = 1;
    else if (op != 6'b111110) il = 1;
    return mk(1, ti, sh, bq, bn, j, pc, rd, mem, wb, op, h, il);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit run = !m_halted && (m_drain == 0);
    bit acc = valid_i && !flush_i && !stall_i && run && (opcode_i == 6'b111111);
    if (flush_i) m_bundle = '0;
    else if (!stall_i) m_bundle = (valid_i && run) ? ref_decode(opcode_i, funct_i) : '0;
    if (run) begin
      if (acc) m_drain = DC;
    end else if (!m_halted) begin
      if (flush_i) m_drain = 0;
      else if (m_drain == 1) begin m_halted = 1; m_drain = 0; end
      else m_drain--;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock_i);
    #1;
    check("model_bundle", 32'(dut_vec()), 32'(m_bundle));
    check("model_fetch_en", 32'(fetch_enable_o), 32'(!m_halted && m_drain == 0));
    check("model_halted", 32'(halted_o), 32'(m_halted));
  endtask

  task automatic drive(logic v, logic [5:0] op, logic [5:0] f, logic st, logic fl);
    valid_i = v; opcode_i = op; funct_i = f; stall_i = st; flush_i = fl;
  endtask

  // Asserts reset in the middle of a cycle and checks outputs clear immediately.
  task automatic do_reset();
    #2;
    reset_i = 1'b1;
    #1;
    m_bundle = '0; m_drain = 0; m_halted = 0;
    check("reset_bundle", 32'(dut_vec()), 32'd0);
    check("reset_fetch_en", 32'(fetch_enable_o), 32'd1);
    check("reset_halted", 32'(halted_o), 32'd0);
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
  endtask

  vec_t vecs[$];
  logic [5:0] op_pool[$];

  initial begin
    reset_i = 1'b1;
    drive(0, 0, 0, 0, 0);
    m_bundle = '0; m_drain = 0; m_halted = 0;
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    check("init_bundle", 32'(dut_vec()), 32'd0);
    check("init_fetch_en", 32'(fetch_enable_o), 32'd1);

    vecs.push_back('{6'b000000, 6'b000000, mk(1,0,0,0,0,0,2'b00,2'b00,6'b000000,3'b000,6'b000000,0,0), "nop_r"});
    vecs.push_back('{6'b000000, 6'b000010, mk(1,0,1,0,0,0,2'b00,2'b01,6'b000000,3'b101,6'b000000,0,0), "srl"});
    vecs.push_back('{6'b000000, 6'b100000, mk(1,0,0,0,0,0,2'b00,2'b01,6'b000000,3'b101,6'b000000,0,0), "add"});
    vecs.push_back('{6'b000000, 6'b001000, mk(1,0,0,0,0,1,2'b00,2'b00,6'b000000,3'b000,6'b000000,0,0), "jr"});
    vecs.push_back('{6'b000000, 6'b001001, mk(1,0,0,0,0,1,2'b00,2'b01,6'b000000,3'b110,6'b000000,0,0), "jalr"});
    vecs.push_back('{6'b001101, 6'b000000, mk(1,1,0,0,0,0,2'b00,2'b00,6'b000000,3'b101,6'b001101,0,0), "ori"});
    vecs.push_back('{6'b100000, 6'b000000, mk(1,1,0,0,0,0,2'b00,2'b00,6'b110001,3'b100,6'b100000,0,0), "lb"});
    vecs.push_back('{6'b100101, 6'b000000, mk(1,1,0,0,0,0,2'b00,2'b00,6'b010010,3'b100,6'b100101,0,0), "lhu"});
    vecs.push_back('{6'b010011, 6'b000000, mk(1,1,0,0,0,0,2'b00,2'b00,6'b010100,3'b100,6'b010011,0,0), "lwu"});
    vecs.push_back('{6'b101001, 6'b000000, mk(1,1,0,0,0,0,2'b00,2'b00,6'b001010,3'b000,6'b101001,0,0), "sh"});
    vecs.push_back('{6'b101011, 6'b000000, mk(1,1,0,0,0,0,2'b00,2'b00,6'b001100,3'b000,6'b101011,0,0), "sw"});
    vecs.push_back('{6'b000101, 6'b000000, mk(1,1,0,0,1,0,2'b10,2'b00,6'b000000,3'b000,6'b000101,0,0), "bne"});
    vecs.push_back('{6'b110001, 6'b000000, mk(1,0,0,0,0,1,2'b01,2'b00,6'b000000,3'b000,6'b110001,0,0), "j"});
    vecs.push_back('{6'b000011, 6'b000000, mk(1,0,0,0,0,1,2'b01,2'b10,6'b000000,3'b110,6'b000011,0,0), "jal"});
    vecs.push_back('{6'b111110, 6'b000000, mk(1,0,0,0,0,0,2'b00,2'b00,6'b000000,3'b000,6'b111110,0,0), "nop"});
    vecs.push_back('{6'b011111, 6'b000000, mk(1,0,0,0,0,0,2'b00,2'b00,6'b000000,3'b000,6'b011111,0,1), "illegal"});

    foreach (vecs[i]) begin
      drive(1, vecs[i].op, vecs[i].funct, 0, 0);
      tick();
      check(vecs[i].name, 32'(dut_vec()), 32'(vecs[i].exp));
    end

    // ADDI, then reset asserted mid-cycle
    drive(1, 6'b001000, 0, 0, 0);
    tick();
    check("addi_valid", 32'(valid_o), 32'd1);
    check("addi_tipei", 32'(tipeI_o), 32'd1);
    check("addi_wb", 32'(wb_signals_o), 32'b101);
    check("addi_mem", 32'(mem_signals_o), 32'd0);
    do_reset();

    // LW then stalled with BEQ waiting on the input
    drive(1, 6'b100011, 0, 0, 0);
    tick();
    drive(1, 6'b000100, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_mem", 32'(mem_signals_o), 32'b110100);
      check("stall_wb", 32'(wb_signals_o), 32'b100);
    end
    stall_i = 0;
    tick();
    check("beq_after_stall", 32'(beq_o), 32'd1);
    check("beq_pc_src", 32'(pc_src_o), 32'b10);

    // flush overrides stall
    drive(1, 6'b000100, 0, 1, 1);
    tick();
    check("flush_stall_valid", 32'(valid_o), 32'd0);
    check("flush_stall_beq", 32'(beq_o), 32'd0);

    // HALT drains for DC edges then sticks
    drive(1, 6'b111111, 0, 0, 0);
    tick();
    check("halt_fetch_off", 32'(fetch_enable_o), 32'd0);
    check("halt_signal", 32'(halt_signal_o), 32'd1);
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k < DC; k++) begin
      tick();
      check("drain_not_halted", 32'(halted_o), 32'd0);
    end
    tick();
    check("halted_rise", 32'(halted_o), 32'd1);
    drive(1, 6'b001000, 0, 0, 1);
    tick();
    check("halted_sticky", 32'(halted_o), 32'd1);
    check("halted_bubble", 32'(valid_o), 32'd0);
    do_reset();

    // HALT aborted by flush on the second drain cycle
    drive(1, 6'b111111, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    flush_i = 1;
    tick();
    check("abort_fetch_en", 32'(fetch_enable_o), 32'd1);
    flush_i = 0;
    for (int k = 0; k < DC + 1; k++) begin
      tick();
      check("abort_no_halt", 32'(halted_o), 32'd0);
    end
    drive(1, 6'b001000, 0, 0, 0);
    tick();
    check("abort_run_valid", 32'(valid_o), 32'd1);

    // illegal opcode and JALR
    drive(1, 6'b011111, 6'b000000, 0, 0);
    tick();
    check("ill_flag", 32'(illegal_o), 32'd1);
    check("ill_wb", 32'(wb_signals_o), 32'd0);
    check("ill_mem", 32'(mem_signals_o), 32'd0);
    drive(1, 6'b000000, 6'b001001, 0, 0);
    tick();
    check("jalr_wb", 32'(wb_signals_o), 32'b110);
    check("jalr_regdest", 32'(regDest_signal_o), 32'b01);

    // random stimulus against the model
    op_pool = '{6'b000000, 6'b000000, 6'b001000, 6'b001010, 6'b001100, 6'b001111, 6'b100000,
                6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b010011, 6'b101000, 6'b101001,
                6'b101011, 6'b000100, 6'b000101, 6'b110001, 6'b000011, 6'b111110, 6'b111111};
    for (int n = 0; n < 600; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, op_pool.size() - 1)];
      fn = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 9)) : 6'($urandom);
      drive($urandom_range(0, 3) != 0, op, fn, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      tick();
      if (m_halted && $urandom_range(0, 3) == 0) begin
        drive(0, 0, 0, 0, 0);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
